arb_grant_dispatch: RTL
=======================

Name: arb_grant_dispatch

Overview:
Downstream consumer of the 4-way round-robin arbiter. It collects valid/data requests from N_REQ sources and drives them as the arbiter's req vector. It samples the arbiter's one-hot grant, captures the winning source's payload, and forwards it on a single valid/ready output channel tagged with the source index. It also supervises the arbiter: grant timeout, malformed grants, and a transfer counter.

Parameters:
N_REQ, 4, number of requesting sources; equals arbiter width.
DATA_W, 8, payload width per source.
GNT_TIMEOUT, 15, maximum cycles in REQ without a usable grant before aborting; must be ≥1.
ID_W, $clog2(N_REQ), width of the source index (derived; not overridden).

Ports:
clk  in  1  single clock; all logic on rising edge.
rst  in  1  reset: one clock; reset is synchronous and active-high.
src_valid  in  N_REQ  per-source request valid; a source holds it with stable data until accepted.
src_data  in  N_REQ*DATA_W  per-source payload; source i occupies bits [i*DATA_W +: DATA_W].
src_ready  out  N_REQ  one-hot accept pulse; source i is accepted in a cycle where src_valid[i] & src_ready[i].
arb_req  out  N_REQ  request vector to arbiter.
arb_grant  in  N_REQ  arbiter grant; registered in the arbiter, responds the cycle after req.
out_valid  out  1  output payload valid.
out_data  out  DATA_W  captured payload.
out_src_id  out  ID_W  binary index of the granted source.
out_ready  in  1  downstream ready.
busy  out  1  high whenever state != IDLE.
err_timeout  out  1  sticky: a grant timeout occurred.
err_grant  out  1  sticky: arb_grant was non-zero and not one-hot while in REQ.
xfer_count  out  16  count of completed output handshakes; wraps 0xFFFF -> 0.

Behaviour:
- Reset values: state=IDLE; out_valid=0; out_data=0; out_src_id=0; src_ready=0; arb_req=0; busy=0; err_timeout=0; err_grant=0; xfer_count=0; timeout counter=0.
- Reset asserted mid-operation aborts any captured payload; the payload is not delivered, and sources not yet accepted keep their valid.
- FSM has three states: IDLE, REQ, SEND.
- IDLE:
  - arb_req=0.
  - If |src_valid, go to REQ next cycle.
- REQ:
  - arb_req=src_valid, combinational, so a source dropping valid (illegal but tolerated) removes its request immediately.
  - The timeout counter increments each REQ cycle without capture.
  - Usable grant = arb_grant one-hot AND (arb_grant & src_valid) != 0. On a usable grant, in the same cycle:
    - src_ready=arb_grant;
    - at the edge, capture out_data=src_data[idx], out_src_id=idx, clear timeout counter, go to SEND.
  - arb_grant==0: stay in REQ.
  - One-hot grant to a non-valid source (stale): no capture, no error, stay in REQ.
  - Non-zero, non-one-hot grant: set err_grant, no capture, src_ready=0, stay in REQ.
  - Timeout: the counter reaching GNT_TIMEOUT with no capture sets err_timeout, clears the counter, and returns to IDLE. A usable grant in the same cycle as the timeout wins: capture, no error.
- SEND:
  - out_valid=1; out_data and out_src_id held stable until handshake.
  - arb_req=0 and src_ready=0, so the arbiter sees no requests.
  - On out_valid & out_ready: xfer_count+1; then go to REQ if |src_valid, else IDLE.
  - out_valid deasserts the cycle after the handshake.
- Latency:
  - src_valid rising in IDLE -> arb_req at cycle +1 -> earliest grant at +2 -> src_ready at +2 -> out_valid at +3.
  - Best-case throughput: one transfer per 3 cycles with out_ready held high.
- src_ready is never asserted outside REQ, and at most one bit is ever set.
- err_* flags are cleared only by rst.

Test Plan:
- Single source: src_valid=4'b0100, data2=0xA5, arbiter live, out_ready=1 -> src_ready=4'b0100 for exactly one cycle; out_valid at cycle 3 with out_data=0xA5, out_src_id=2; xfer_count=1; back to IDLE.
- Backpressure: all four sources valid with data 0x10/0x21/0x32/0x43, out_ready low for 5 cycles during SEND -> out_data/out_src_id stable and arb_req=0 throughout SEND. After 4 handshakes, each id 0–3 appears exactly once in rotation order, and xfer_count=4.
- Timeout: arbiter held in reset (grant=0), src_valid=4'b0001, GNT_TIMEOUT=15 -> after 15 REQ cycles err_timeout=1, state IDLE, src_ready never asserted; re-enters REQ the next cycle.
- Malformed grant: force arb_grant=4'b0011 in REQ -> err_grant=1, no capture, src_ready=0. Then arb_grant=4'b0001 -> normal capture of source 0.
- Stale grant plus reset: grant 4'b1000 while src_valid[3]=0 -> no capture, stay in REQ. Then assert rst while in SEND -> next cycle out_valid=0, busy=0, err flags=0, xfer_count=0.
- Wrap: preload via 65535 handshakes (or force) -> next handshake gives xfer_count=0.

Source files
------------

// File: rtl/arb_grant_dispatch.sv
// Consumer side of a round-robin arbiter: turns per-source valid/data into arbiter
// requests, captures the granted payload and forwards it on one tagged output channel.
module arb_grant_dispatch #(
    parameter int N_REQ       = 4,
    parameter int DATA_W      = 8,
    parameter int GNT_TIMEOUT = 15,
    localparam int ID_W       = $clog2(N_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          src_valid,
    input  logic [N_REQ*DATA_W-1:0]   src_data,
    output logic [N_REQ-1:0]          src_ready,
    output logic [N_REQ-1:0]          arb_req,
    input  logic [N_REQ-1:0]          arb_grant,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic [ID_W-1:0]           out_src_id,
    input  logic                      out_ready,
    output logic                      busy,
    output logic                      err_timeout,
    output logic                      err_grant,
    output logic [15:0]               xfer_count
);

    localparam int TMO_W = $clog2(GNT_TIMEOUT + 1);

    // Handshakes: a source is accepted on src_valid[i] & src_ready[i]; the output
    // transfers on out_valid & out_ready. out_valid, out_data and out_src_id are held
    // stable from capture until that handshake. busy and out_valid together decode
    // the FSM state: IDLE = !busy, SEND = out_valid, REQ = busy & !out_valid.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t              state;
    logic [TMO_W-1:0]    tmo_cnt;
    logic                in_req;
    logic                grant_onehot;
    logic                grant_usable;
    logic                grant_bad;
    logic [ID_W-1:0]     grant_idx;
    logic [DATA_W-1:0]   grant_data;

    assign in_req       = (state == REQ);
    assign grant_onehot = (arb_grant != '0) && ((arb_grant & (arb_grant - 1'b1)) == '0);
    assign grant_usable = in_req && grant_onehot && ((arb_grant & src_valid) != '0);
    assign grant_bad    = in_req && (arb_grant != '0) && !grant_onehot;

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_grant[i]) grant_idx = ID_W'(i);
        end
    end

    assign grant_data = src_data[grant_idx*DATA_W +: DATA_W];

    // Requests pass straight through in REQ so a dropped valid withdraws at once.
    assign arb_req   = in_req ? src_valid : '0;
    assign src_ready = grant_usable ? arb_grant : '0;
    assign out_valid = (state == SEND);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            tmo_cnt     <= '0;
            out_data    <= '0;
            out_src_id  <= '0;
            err_timeout <= 1'b0;
            err_grant   <= 1'b0;
            xfer_count  <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (|src_valid) state <= REQ;
                end
                REQ: begin
                    if (grant_bad) err_grant <= 1'b1;
                    // A usable grant beats a timeout landing in the same cycle.
                    if (grant_usable) begin
                        out_data   <= grant_data;
                        out_src_id <= grant_idx;
                        tmo_cnt    <= '0;
                        state      <= SEND;
                    end else if (tmo_cnt == TMO_W'(GNT_TIMEOUT - 1)) begin
                        err_timeout <= 1'b1;
                        tmo_cnt     <= '0;
                        state       <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        xfer_count <= xfer_count + 16'd1;
                        state      <= (|src_valid) ? REQ : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
